// File: rtl/claw_motion_controller_if.sv
// Claw controller I/O bundle: game/button levels in, motor pulses and status out.
// master drives the buttons; slave is the controller.
interface claw_motion_controller_if;
  logic        game_active;
  logic        btn_left;
  logic        btn_right;
  logic        btn_fwd;
  logic        btn_back;
  logic        btn_drop;
  logic        x_step;
  logic        y_step;
  logic        z_step;
  logic        x_dir;
  logic        y_dir;
  logic        z_dir;
  logic        claw_close;
  logic        busy;
  logic        prize_window;
  logic [2:0]  state;
  logic [15:0] x_pos;
  logic [15:0] y_pos;
  logic [15:0] z_pos;

  modport master (
    output game_active, btn_left, btn_right,
    output btn_fwd, btn_back, btn_drop,
    input  x_step, y_step, z_step,
    input  x_dir, y_dir, z_dir,
    input  claw_close, busy, prize_window,
    input  state, x_pos, y_pos, z_pos
  );

  modport slave (
    input  game_active, btn_left, btn_right,
    input  btn_fwd, btn_back, btn_drop,
    output x_step, y_step, z_step,
    output x_dir, y_dir, z_dir,
    output claw_close, busy, prize_window,
    output state, x_pos, y_pos, z_pos
  );
endinterface

// File: rtl/claw_motion_controller.sv
// Claw machine motion: tick-paced x/y jog in IDLE, then the automatic
// lower / grab / raise / return / release sequence on a drop request.
module claw_motion_controller #(
  parameter int STEP_DIV    = 100000,
  parameter int X_MAX       = 1000,
  parameter int Y_MAX       = 1000,
  parameter int Z_MAX       = 500,
  parameter int HOLD_CYCLES = 50000000
) (
  input logic                     clock,
  input logic                     reset,
  claw_motion_controller_if.slave bus
);
  localparam int TW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [15:0] XM = 16'(X_MAX);
  localparam logic [15:0] YM = 16'(Y_MAX);
  localparam logic [15:0] ZM = 16'(Z_MAX);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOWER   = 3'd1,
    S_GRAB    = 3'd2,
    S_RAISE   = 3'd3,
    S_RETURN  = 3'd4,
    S_RELEASE = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [TW-1:0] tick_q;
  logic [DW-1:0] dwell_q;
  logic [15:0] x_q, y_q, z_q;
  logic        drop_q;
  logic        claw_q, busy_q, prize_q;

  logic tick, jog, ret, drop_rise, dwell_done;
  logic x_up, x_dn, y_up, y_dn, z_up, z_dn;
  logic x_step, y_step, z_step;

  assign tick       = (tick_q == TW'(STEP_DIV - 1));
  assign dwell_done = (dwell_q == DW'(HOLD_CYCLES - 1));
  assign jog        = (state_q == S_IDLE) && bus.game_active;
  assign ret        = (state_q == S_RETURN);
  assign drop_rise  = bus.btn_drop && !drop_q;

  // Opposing buttons cancel; limits block the pulse itself.
  assign x_up = jog && bus.btn_right && !bus.btn_left && (x_q < XM);
  assign x_dn = (jog && bus.btn_left && !bus.btn_right || ret)
                && (x_q != 16'd0);
  assign y_up = jog && bus.btn_back && !bus.btn_fwd && (y_q < YM);
  assign y_dn = (jog && bus.btn_fwd && !bus.btn_back || ret)
                && (y_q != 16'd0);
  assign z_up = (state_q == S_LOWER) && (z_q < ZM);
  assign z_dn = (state_q == S_RAISE) && (z_q != 16'd0);

  assign x_step = tick && (x_up || x_dn);
  assign y_step = tick && (y_up || y_dn);
  assign z_step = tick && (z_up || z_dn);

  assign bus.x_step       = x_step;
  assign bus.y_step       = y_step;
  assign bus.z_step       = z_step;
  assign bus.x_dir        = tick && x_up;
  assign bus.y_dir        = tick && y_up;
  assign bus.z_dir        = tick && z_up;
  assign bus.claw_close   = claw_q;
  assign bus.busy         = busy_q;
  assign bus.prize_window = prize_q;
  assign bus.state        = state_q;
  assign bus.x_pos        = x_q;
  assign bus.y_pos        = y_q;
  assign bus.z_pos        = z_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (jog && drop_rise) state_d = S_LOWER;
      S_LOWER:   if (z_q == ZM) state_d = S_GRAB;
      S_GRAB:    if (dwell_done) state_d = S_RAISE;
      S_RAISE:   if (z_q == 16'd0) state_d = S_RETURN;
      S_RETURN:  if (x_q == 16'd0 && y_q == 16'd0) state_d = S_RELEASE;
      S_RELEASE: if (dwell_done) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      tick_q  <= '0;
      dwell_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      drop_q  <= 1'b1;
      claw_q  <= 1'b0;
      busy_q  <= 1'b0;
      prize_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick ? '0 : tick_q + TW'(1);
      drop_q  <= bus.btn_drop;
      if (state_d != state_q) dwell_q <= '0;
      else if (state_q == S_GRAB || state_q == S_RELEASE)
        dwell_q <= dwell_q + DW'(1);
      else dwell_q <= '0;
      if (x_step) x_q <= x_up ? x_q + 16'd1 : x_q - 16'd1;
      if (y_step) y_q <= y_up ? y_q + 16'd1 : y_q - 16'd1;
      if (z_step) z_q <= z_up ? z_q + 16'd1 : z_q - 16'd1;
      // Status flags follow the next state so they align with state_q.
      claw_q  <= (state_d == S_GRAB) || (state_d == S_RAISE);
      busy_q  <= (state_d != S_IDLE);
      prize_q <= (state_d == S_RELEASE);
    end
  end
endmodule

// File: tb/tb_claw_motion_controller.sv
// Directed bench for claw_motion_controller: jog vectors from a table,
// then hand-written drop, game-over and reset-abort sequences.
module tb_claw_motion_controller;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  claw_motion_controller_if bus();

  claw_motion_controller #(
    .STEP_DIV(4), .X_MAX(8), .Y_MAX(8), .Z_MAX(3), .HOLD_CYCLES(5)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic l, r, f, b, ga;
    int   cyc;
    int   ex, ey, nx, ny;
  } vec_t;

  vec_t v[8];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr_btn();
    bus.btn_left  = 1'b0;
    bus.btn_right = 1'b0;
    bus.btn_fwd   = 1'b0;
    bus.btn_back  = 1'b0;
  endtask

  task automatic run_vec(input int idx);
    int xs, ys;
    xs = 0;
    ys = 0;
    @(posedge clock);
    #1;
    bus.btn_left    = v[idx].l;
    bus.btn_right   = v[idx].r;
    bus.btn_fwd     = v[idx].f;
    bus.btn_back    = v[idx].b;
    bus.game_active = v[idx].ga;
    repeat (v[idx].cyc) begin
      @(negedge clock);
      xs += int'(bus.x_step);
      ys += int'(bus.y_step);
      @(posedge clock);
    end
    #1;
    clr_btn();
    bus.game_active = 1'b1;
    @(negedge clock);
    chk($sformatf("vec%0d x_pos", idx), int'(bus.x_pos), v[idx].ex);
    chk($sformatf("vec%0d y_pos", idx), int'(bus.y_pos), v[idx].ey);
    chk($sformatf("vec%0d x_steps", idx), xs, v[idx].nx);
    chk($sformatf("vec%0d y_steps", idx), ys, v[idx].ny);
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, " state"}, int'(bus.state), 0);
    chk({tag, " x_pos"}, int'(bus.x_pos), 0);
    chk({tag, " y_pos"}, int'(bus.y_pos), 0);
    chk({tag, " z_pos"}, int'(bus.z_pos), 0);
    chk({tag, " steps"}, int'({bus.x_step, bus.y_step, bus.z_step}), 0);
    chk({tag, " dirs"}, int'({bus.x_dir, bus.y_dir, bus.z_dir}), 0);
    chk({tag, " claw"}, int'(bus.claw_close), 0);
    chk({tag, " busy"}, int'(bus.busy), 0);
    chk({tag, " prize"}, int'(bus.prize_window), 0);
  endtask

  initial begin
    int seq[$];
    int prev, claw_bad, prize_n, zup, zdn, zmax, xs, ys, stuck;
    bit saw_rel, found;

    //        l     r     f     b     ga   cyc  ex ey nx ny
    v[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1,  8, 0, 0, 0, 0};
    v[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 40, 8, 0, 8, 0};
    v[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 16, 8, 0, 0, 0};
    v[3] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 24, 2, 0, 6, 0};
    v[4] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 40, 2, 8, 0, 8};
    v[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 28, 2, 1, 0, 7};
    v[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16, 2, 1, 0, 0};
    v[7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0,  8, 2, 1, 0, 0};

    clr_btn();
    bus.btn_drop    = 1'b0;
    bus.game_active = 1'b1;
    repeat (2) @(negedge clock);
    chk_idle_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i);

    // Drop edge while the game is off is ignored.
    bus.game_active = 1'b0;
    bus.btn_drop    = 1'b1;
    stuck = 0;
    repeat (8) begin
      @(negedge clock);
      if (bus.state != 3'd0 || bus.busy) stuck++;
    end
    chk("drop ga=0 state", stuck, 0);
    bus.btn_drop    = 1'b0;
    bus.game_active = 1'b1;
    @(negedge clock);

    // Full sequence from x=2, y=1.
    @(posedge clock);
    #1 bus.btn_drop = 1'b1;
    prev = 0; claw_bad = 0; prize_n = 0;
    zup = 0; zdn = 0; zmax = 0; xs = 0; ys = 0;
    found = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (c == 2) bus.btn_drop = 1'b0;
      if (int'(bus.state) != prev) seq.push_back(int'(bus.state));
      prev = int'(bus.state);
      if (bus.claw_close != (bus.state == 3'd2 || bus.state == 3'd3))
        claw_bad++;
      if (bus.prize_window) prize_n++;
      if (bus.prize_window != (bus.state == 3'd5)) claw_bad++;
      if (bus.z_step && bus.z_dir) zup++;
      if (bus.z_step && !bus.z_dir) zdn++;
      if (bus.x_step) xs++;
      if (bus.y_step) ys++;
      if (int'(bus.z_pos) > zmax) zmax = int'(bus.z_pos);
      if (bus.state == 3'd0 && seq.size() > 0) begin
        found = 1'b1;
        break;
      end
    end
    chk("seq completed", int'(found), 1);
    chk("seq length", seq.size(), 6);
    for (int k = 0; k < 6; k++)
      if (k < seq.size())
        chk($sformatf("seq state[%0d]", k), seq[k], (k + 1) % 6);
    chk("claw/prize vs state", claw_bad, 0);
    chk("prize cycles", prize_n, 5);
    chk("z up steps", zup, 3);
    chk("z down steps", zdn, 3);
    chk("z max", zmax, 3);
    chk("return x steps", xs, 2);
    chk("return y steps", ys, 1);
    chk("final x", int'(bus.x_pos), 0);
    chk("final y", int'(bus.y_pos), 0);
    chk("final z", int'(bus.z_pos), 0);

    // Game ends during LOWER; the sequence still finishes.
    @(posedge clock);
    #1 bus.btn_drop = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (bus.state == 3'd1) begin
        found = 1'b1;
        break;
      end
    end
    chk("ga drop: reached LOWER", int'(found), 1);
    bus.game_active = 1'b0;
    bus.btn_drop    = 1'b0;
    found = 1'b0;
    saw_rel = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (bus.state == 3'd5) saw_rel = 1'b1;
      if (bus.state == 3'd0) begin
        found = 1'b1;
        break;
      end
    end
    chk("ga drop: back to IDLE", int'(found), 1);
    chk("ga drop: went through RELEASE", int'(saw_rel), 1);
    bus.game_active = 1'b1;

    // Reset in RAISE at z=2, drop held through reset release.
    @(posedge clock);
    #1 bus.btn_drop = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clock);
      if (bus.state == 3'd3 && bus.z_pos == 16'd2) begin
        found = 1'b1;
        break;
      end
    end
    chk("reached RAISE z=2", int'(found), 1);
    reset = 1'b1;
    #1;
    chk_idle_zero("mid reset");
    @(negedge clock);
    reset = 1'b0;
    stuck = 0;
    repeat (20) begin
      @(negedge clock);
      if (bus.state != 3'd0 || bus.busy) stuck++;
    end
    chk("held drop after reset", stuck, 0);
    bus.btn_drop = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
